sha256_round_ctrl: RTL and testbench
====================================

# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. It accepts one 512-bit block per start handshake and walks the datapath through its phases: initial load, 64 rounds, final add, and a done pulse. Along the way it issues the round index for K[t] lookup and the message-schedule source select. It sits between the block-feeding logic and the round/schedule registers and owns no hash data itself.

## Interface
- ROUNDS, 64, number of compression rounds; the counter terminates at ROUNDS-1.
- IDX_W, 6, width of the round index, equal to $clog2(ROUNDS).

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request to compress one block; accepted only in a cycle where ready_o=1.
- first_blk_i  in  1  sampled with an accepted start; 1 means initialise the hash state from the IV.
- hold_i  in  1  stalls round progress; honoured in ROUND only.
- ready_o  out  1  controller is idle and can accept start_i.
- busy_o  out  1  controller is in LOAD, ROUND, FINAL or DONE.
- init_iv_o  out  1  load the IV into the H registers; asserted in LOAD when the latched first flag is 1.
- load_blk_o  out  1  load the message block into W[0..15] and copy H into a..h.
- round_en_o  out  1  update a..h and the schedule this cycle.
- round_idx_o  out  IDX_W  current round t.
- w_sel_o  out  1  W source: 0 = message word (t<16), 1 = computed schedule word (t≥16).
- final_add_o  out  1  H ← H + a..h.
- done_o  out  1  one-cycle pulse; the digest is valid in H.

## Operation
- FSM states are IDLE, LOAD, ROUND, FINAL, DONE. All outputs are Moore decodes of the registered state and counter.
- **IDLE**
  - ready_o=1.
  - start_i=1 → LOAD, latch first_blk_i into first_q, clear the counter.
- **LOAD** (exactly 1 cycle)
  - load_blk_o=1, init_iv_o=first_q.
  - Next state is ROUND with t=0.
- **ROUND**
  - round_en_o = ~hold_i.
  - If hold_i=0: t increments. At t=ROUNDS-1 the next state is FINAL and t stays at ROUNDS-1.
  - If hold_i=1: t and state freeze.
- **FINAL** (1 cycle): final_add_o=1, then DONE. hold_i is ignored.
- **DONE** (1 cycle): done_o=1, then IDLE.
- Derived outputs:
  - w_sel_o = (t ≥ 16) in ROUND, 0 otherwise.
  - round_idx_o = t in ROUND, FINAL and DONE, 0 in IDLE and LOAD.
- The counter is unsigned, IDX_W bits wide, and never wraps: its terminal value is fixed at ROUNDS-1.
- start_i outside IDLE is ignored. There is no queueing and the request is not remembered.
- first_blk_i is sampled only on an accepted start.

## Timing
- Reset values: ready_o=1; busy_o, init_iv_o, load_blk_o, round_en_o, w_sel_o, final_add_o, done_o = 0; round_idx_o=0; state=IDLE; first_q=0.
- rst_i during any state forces IDLE at the next edge. No done_o or final_add_o is issued for the interrupted block.
- Pipeline, with start accepted at edge 0 and no holds:
  - LOAD in cycle 1.
  - ROUND t=0..63 in cycles 2..65.
  - FINAL in cycle 66.
  - done_o in cycle 67.
  - ready_o=1 again in cycle 68.
- Every hold cycle in ROUND adds exactly one cycle to the total latency.
- A back-to-back start is first accepted in cycle 68: the minimum throughput is 68 cycles per block.
- rst_i and start_i asserted together: reset wins.
- hold_i asserted while t=63: FINAL is delayed until hold_i falls.
- load_blk_o, final_add_o and done_o are each exactly one cycle per block.
- round_en_o is asserted exactly ROUNDS times per block.

## Structure
- Shared package sha256_pkg holds:
  - typedef enum logic [2:0] sha_state_t {IDLE, LOAD, ROUND, FINAL, DONE};
  - the constants SHA_ROUNDS=64 and SHA_MSG_WORDS=16;
  - the K[0..63] constant array, so the datapath indexes it with round_idx_o.
- One sub-module, sha256_round_cnt: an IDX_W-bit counter with clear, enable and terminal-count flag (t==ROUNDS-1).
- The FSM and output decode stay in the top module.

## Test plan
- **Reset:** assert rst_i 2 cycles → ready_o=1, all other outputs 0, round_idx_o=0.
- **Single first block:**
  - Stimulus: start_i=1 with first_blk_i=1 at edge 0, no hold.
  - Response: init_iv_o=load_blk_o=1 in cycle 1; round_en_o high in cycles 2..65; round_idx_o 0..63; w_sel_o rises at t=16 (cycle 18); final_add_o in cycle 66; done_o in cycle 67.
- **Continuation block and ignored start:**
  - Stimulus: first_blk_i=0; start_i held high through the whole run.
  - Response: init_iv_o stays 0; exactly one done_o; a second block is accepted in cycle 68.
- **Hold:**
  - Stimulus: hold_i=1 for 3 cycles at t=10, and for 2 cycles at t=63.
  - Response: round_idx_o frozen with round_en_o=0 during each hold; done_o in cycle 72; 64 round_en_o pulses in total.
- **Reset mid-operation:**
  - Stimulus: rst_i at t=40.
  - Response: IDLE the next cycle, ready_o=1, no final_add_o or done_o; the next start runs a full 68-cycle sequence.
- **Simultaneous start and reset:**
  - Stimulus: start_i=rst_i=1 in IDLE.
  - Response: remains IDLE, load_blk_o stays 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, round/word counts and the K constants.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } sha_state_t;

  localparam int unsigned SHA_ROUNDS    = 64;
  localparam int unsigned SHA_MSG_WORDS = 16;

  localparam logic [31:0] SHA_K [SHA_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sha_k(input logic [5:0] idx);
    return SHA_K[idx];
  endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round counter: clears on request, advances when enabled and saturates at ROUNDS-1.
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA_ROUNDS,
  parameter int unsigned IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [IDX_W-1:0] Last = IDX_W'(ROUNDS - 1);

  logic [IDX_W-1:0] r_cnt;

  assign tc_o  = (r_cnt == Last);
  assign cnt_o = r_cnt;

  // Holding at the terminal value lets FINAL/DONE keep reporting the last round.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && !tc_o) begin
      r_cnt <= r_cnt + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: IDLE -> LOAD -> ROUND x ROUNDS -> FINAL -> DONE per block.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA_ROUNDS,
  parameter int unsigned IDX_W  = $clog2(ROUNDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             first_blk_i,
  input  logic             hold_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             init_iv_o,
  output logic             load_blk_o,
  output logic             round_en_o,
  output logic [IDX_W-1:0] round_idx_o,
  output logic             w_sel_o,
  output logic             final_add_o,
  output logic             done_o
);

  localparam logic [IDX_W-1:0] MsgWords = IDX_W'(SHA_MSG_WORDS);

  sha_state_t       r_state;
  sha_state_t       w_state_d;
  logic             r_first;
  logic             w_accept;
  logic             w_cnt_en;
  logic             w_tc;
  logic [IDX_W-1:0] w_t;

  assign w_accept = (r_state == IDLE) && start_i;
  assign w_cnt_en = (r_state == ROUND) && !hold_i;

  sha256_round_cnt #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_round_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_accept),
    .en_i  (w_cnt_en),
    .cnt_o (w_t),
    .tc_o  (w_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_first <= first_blk_i;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_d = LOAD;
      LOAD:    w_state_d = ROUND;
      ROUND:   if (!hold_i && w_tc) w_state_d = FINAL;
      FINAL:   w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o     = 1'b0;
    busy_o      = 1'b0;
    init_iv_o   = 1'b0;
    load_blk_o  = 1'b0;
    round_en_o  = 1'b0;
    round_idx_o = '0;
    w_sel_o     = 1'b0;
    final_add_o = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      IDLE: ready_o = 1'b1;
      LOAD: begin
        busy_o     = 1'b1;
        load_blk_o = 1'b1;
        init_iv_o  = r_first;
      end
      ROUND: begin
        busy_o      = 1'b1;
        round_en_o  = !hold_i;
        round_idx_o = w_t;
        w_sel_o     = (w_t >= MsgWords);
      end
      FINAL: begin
        busy_o      = 1'b1;
        round_idx_o = w_t;
        final_add_o = 1'b1;
      end
      DONE: begin
        busy_o      = 1'b1;
        round_idx_o = w_t;
        done_o      = 1'b1;
      end
      default: ready_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: checks every output each cycle against hand-derived phases.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       first_blk_i;
  logic       hold_i;
  logic       ready_o;
  logic       busy_o;
  logic       init_iv_o;
  logic       load_blk_o;
  logic       round_en_o;
  logic [5:0] round_idx_o;
  logic       w_sel_o;
  logic       final_add_o;
  logic       done_o;

  int n_vec = 0;
  int n_err = 0;
  int n_ren;
  int n_done;

  always #5 clk = ~clk;

  sha256_round_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .first_blk_i (first_blk_i),
    .hold_i      (hold_i),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .init_iv_o   (init_iv_o),
    .load_blk_o  (load_blk_o),
    .round_en_o  (round_en_o),
    .round_idx_o (round_idx_o),
    .w_sel_o     (w_sel_o),
    .final_add_o (final_add_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ph: 0 idle, 1 load, 2 round, 3 final, 4 done
  task automatic exp_state(input string tag, input int ph, input int t, input bit iv,
                           input bit ren);
    check({tag, ".ready"}, 32'(ready_o), 32'(ph == 0));
    check({tag, ".busy"}, 32'(busy_o), 32'(ph != 0));
    check({tag, ".init_iv"}, 32'(init_iv_o), 32'(ph == 1 && iv));
    check({tag, ".load"}, 32'(load_blk_o), 32'(ph == 1));
    check({tag, ".round_en"}, 32'(round_en_o), 32'(ph == 2 && ren));
    check({tag, ".idx"}, 32'(round_idx_o), (ph >= 2) ? t : 0);
    check({tag, ".w_sel"}, 32'(w_sel_o), 32'(ph == 2 && t >= 16));
    check({tag, ".final"}, 32'(final_add_o), 32'(ph == 3));
    check({tag, ".done"}, 32'(done_o), 32'(ph == 4));
    if (round_en_o === 1'b1) n_ren++;
    if (done_o === 1'b1) n_done++;
  endtask

  // Hold-free timeline with the start accepted at edge 0.
  task automatic nominal(input int c, output int ph, output int t);
    t = 0;
    if (c == 1) ph = 1;
    else if (c <= 65) begin ph = 2; t = c - 2; end
    else if (c == 66) begin ph = 3; t = 63; end
    else if (c == 67) begin ph = 4; t = 63; end
    else ph = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_state(tag, 0, 0, 1'b0, 1'b0);
    rst_i = 1'b0;
  endtask

  // Entered and left at a falling edge.
  task automatic run_nominal(input string tag, input bit first, input bit keep_start,
                             input int last_c);
    int ph;
    int t;
    n_ren  = 0;
    n_done = 0;
    start_i     = 1'b1;
    first_blk_i = first;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      start_i = keep_start;
      @(negedge clk);
      nominal(c, ph, t);
      if (keep_start && c == 69) ph = 1;
      exp_state($sformatf("%s.c%0d", tag, c), ph, t, first, 1'b1);
      if (c == 67) begin
        check({tag, ".n_round_en"}, n_ren, 64);
        check({tag, ".n_done"}, n_done, 1);
      end
    end
    start_i = 1'b0;
  endtask

  initial begin
    int ph;
    int t;
    bit hold_now;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    first_blk_i = 1'b0;
    hold_i      = 1'b0;
    do_reset("RST");

    check("K0", sha_k(6'd0), 32'h428a2f98);
    check("K63", sha_k(6'd63), 32'hc67178f2);

    run_nominal("A", 1'b1, 1'b0, 68);

    // start held high: only one done, second block accepted at edge 68
    run_nominal("B", 1'b0, 1'b1, 69);
    do_reset("RST2");

    // start and reset together in IDLE
    start_i = 1'b1;
    rst_i   = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk);
    exp_state("E.c1", 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    exp_state("E.c2", 0, 0, 1'b0, 1'b0);

    // hold 3 cycles at t=10 (cycles 12..14) and 2 cycles at t=63 (cycles 68..69)
    n_ren       = 0;
    n_done      = 0;
    start_i     = 1'b1;
    first_blk_i = 1'b1;
    for (int c = 1; c <= 73; c++) begin
      @(posedge clk);
      #1;
      start_i  = 1'b0;
      hold_now = (c >= 12 && c <= 14) || (c >= 68 && c <= 69);
      hold_i   = hold_now;
      @(negedge clk);
      t = 63;
      if (c == 1) begin ph = 1; t = 0; end
      else if (c <= 70) begin
        ph = 2;
        if (c <= 12) t = c - 2;
        else if (c <= 15) t = 10;
        else if (c <= 68) t = c - 5;
      end
      else if (c == 71) ph = 3;
      else if (c == 72) ph = 4;
      else ph = 0;
      exp_state($sformatf("C.c%0d", c), ph, t, 1'b1, !hold_now);
    end
    hold_i = 1'b0;
    check("C.n_round_en", n_ren, 64);
    check("C.n_done", n_done, 1);

    // reset at t=40 (cycle 42), then a full block
    n_done      = 0;
    start_i     = 1'b1;
    first_blk_i = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      rst_i   = (c == 42);
      @(negedge clk);
      if (c <= 42) nominal(c, ph, t);
      else begin ph = 0; t = 0; end
      exp_state($sformatf("D.c%0d", c), ph, t, 1'b1, 1'b1);
    end
    check("D.n_done", n_done, 0);
    run_nominal("D2", 1'b0, 1'b0, 68);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
